// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: cpu-side data-port bundle between the cpu (master) and the
// data-memory controller (slave).
interface dmem_ctrl_if;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output cs, rd, wr, size, sign_ext, addr, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  cs, rd, wr, size, sign_ext, addr, wdata,
        output rdata, ready, busy, err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller with base-address translation,
// byte/half/word accesses (little-endian, optional sign extension),
// WAIT_CYCLES wait states before a one-cycle ready pulse, and err for
// misaligned, out-of-range or malformed requests.
// Optional macro DMEM_CLR_EN: after reset the controller zero-fills the
// whole memory (state CLEAR) before accepting requests.
module dmem_ctrl #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input logic        clk_in,
    input logic        reset,
    dmem_ctrl_if.slave bus
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

`ifdef DMEM_CLR_EN
    typedef enum logic [1:0] {IDLE, WAIT, DONE, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
`endif

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [3:0]    wait_cnt;
    logic [AW-1:0] idx_q;
    logic [1:0]    lane_q;
    logic [1:0]    size_q;
    logic          sext_q;
    logic          wr_q;
    logic          bad_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          ready_q;
    logic          busy_q;
    logic          err_q;
`ifdef DMEM_CLR_EN
    logic [AW-1:0] clr_idx;
    logic          clr_we;
`endif

    logic [31:0]   off;
    logic          bad_req;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   rd_val;
    logic [31:0]   wr_data;
    logic [3:0]    lane_en;
    logic          mem_we;

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;

    // Translate the incoming address and classify the request as bad before accepting it.
    always_comb begin
        off     = bus.addr - BASE_ADDR;
        bad_req = (off >= SPAN)
                || (bus.size == 2'b11)
                || ((bus.size == 2'b01) && off[0])
                || ((bus.size == 2'b10) && (off[1:0] != 2'b00))
                || (bus.rd && bus.wr);
    end

    // Pick the addressed lane(s) out of the stored word and extend to 32 bits.
    always_comb begin
        rd_word = mem[idx_q];
        rd_byte = rd_word[{lane_q, 3'b000} +: 8];
        rd_half = lane_q[1] ? rd_word[31:16] : rd_word[15:0];
        rd_val  = rd_word;
        case (size_q)
            2'b00:   rd_val = sext_q ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
            2'b01:   rd_val = sext_q ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
            default: rd_val = rd_word;
        endcase
    end

    // Replicate write data across lanes and enable only the lanes being stored.
    always_comb begin
        lane_en = 4'b1111;
        wr_data = wdata_q;
        case (size_q)
            2'b00: begin
                lane_en = 4'b0001 << lane_q;
                wr_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_en = lane_q[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_en = 4'b1111;
                wr_data = wdata_q;
            end
        endcase
        mem_we = reset && (state == DONE) && wr_q && !bad_q;
`ifdef DMEM_CLR_EN
        clr_we = reset && (state == CLEAR) && busy_q;
`endif
    end

    // Storage: byte-lane writes in DONE, zero-fill while clearing; never reset.
    always_ff @(posedge clk_in) begin
`ifdef DMEM_CLR_EN
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end
`endif
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[idx_q][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Request FSM: accept, count wait states, complete with a registered ready pulse.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
`ifdef DMEM_CLR_EN
            state   <= CLEAR;
            clr_idx <= '0;
`else
            state   <= IDLE;
`endif
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
            idx_q    <= '0;
            lane_q   <= '0;
            size_q   <= '0;
            sext_q   <= 1'b0;
            wr_q     <= 1'b0;
            bad_q    <= 1'b0;
            wdata_q  <= '0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cs && (bus.rd || bus.wr)) begin
                        idx_q   <= off[AW+1:2];
                        lane_q  <= off[1:0];
                        size_q  <= bus.size;
                        sext_q  <= bus.sign_ext;
                        wdata_q <= bus.wdata;
                        wr_q    <= bus.wr;
                        bad_q   <= bad_req;
                        busy_q  <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= DONE;
                        end else begin
                            wait_cnt <= 4'(WAIT_CYCLES - 1);
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    err_q   <= bad_q;
                    if (bad_q) begin
                        rdata_q <= '0;
                    end else if (!wr_q) begin
                        rdata_q <= rd_val;
                    end
                    state <= IDLE;
                end
`ifdef DMEM_CLR_EN
                CLEAR: begin
                    if (!busy_q) begin
                        busy_q <= 1'b1;
                    end else if (clr_idx == AW'(DEPTH - 1)) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        clr_idx <= clr_idx + AW'(1);
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
